// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: event channel indices
// and the default channel count.
package perf_pkg;

  localparam int NUM_EVT_DEFAULT = 8;

  localparam int EVT_J         = 0;
  localparam int EVT_R         = 1;
  localparam int EVT_I         = 2;
  localparam int EVT_LOAD      = 3;
  localparam int EVT_STORE     = 4;
  localparam int EVT_BR_TAKEN  = 5;
  localparam int EVT_SYSCALL   = 6;
  localparam int EVT_EXCEPTION = 7;

endpackage

// File: rtl/perf_counter.sv
// Single CNT_W event counter with wrap/saturate behaviour and an overflow
// pulse raised whenever an increment lands on an all-ones value.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             mode,
  output logic [CNT_W-1:0] value,
  output logic             ovf_pulse
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max = &cnt_q;

  always_comb begin
    cnt_d     = cnt_q;
    ovf_pulse = inc & at_max;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      // mode=1 holds at all-ones; mode=0 rolls over to zero.
      if (at_max) cnt_d = mode ? cnt_q : '0;
      else        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_EVT event counters plus a cycle counter, with sticky overflow,
// halt freeze, synchronous clear, atomic snapshot and a registered read port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int NUM_EVT  = NUM_EVT_DEFAULT,
  parameter int SAT_MODE = 0,
  parameter int SEL_W    = $clog2(NUM_EVT+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               halt,
  input  logic               clear,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               snap,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]   rd_data,
  output logic [NUM_EVT:0]   ovf,
  output logic               frozen
);

  localparam logic MODE = (SAT_MODE != 0);

  logic                          act;
  logic [NUM_EVT:0]              inc_vec;
  logic [NUM_EVT:0]              ovf_pulse;
  logic [NUM_EVT:0][CNT_W-1:0]   live;
  logic [NUM_EVT:0][CNT_W-1:0]   shadow_q, shadow_d;
  logic [NUM_EVT:0]              ovf_q, ovf_d;
  logic                          frozen_q, frozen_d;
  logic [CNT_W-1:0]              rd_data_q, rd_data_d;

  assign act     = en & ~frozen_q;
  // Top slot is the cycle counter: its increment is the activity flag itself.
  assign inc_vec = {1'b1, evt} & {(NUM_EVT+1){act}};

  for (genvar i = 0; i <= NUM_EVT; i++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_vec[i]),
      .clr       (clear),
      .mode      (MODE),
      .value     (live[i]),
      .ovf_pulse (ovf_pulse[i])
    );
  end

  always_comb begin
    frozen_d = clear ? 1'b0 : (frozen_q | halt);
    ovf_d    = clear ? '0 : (ovf_q | ovf_pulse);
    // Shadows capture the pre-edge live values, so a same-cycle clear or
    // increment never leaks into the snapshot.
    shadow_d = snap ? live : shadow_q;
    rd_data_d = '0;
    for (int i = 0; i <= NUM_EVT; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data_d = shadow_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frozen_q  <= 1'b0;
      ovf_q     <= '0;
      shadow_q  <= '0;
      rd_data_q <= '0;
    end else begin
      frozen_q  <= frozen_d;
      ovf_q     <= ovf_d;
      shadow_q  <= shadow_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign ovf     = ovf_q;
  assign frozen  = frozen_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a 32-bit wrap instance plus 4-bit
// wrap and saturate instances sharing the same stimulus.
module tb_perf_counter_bank;

  localparam int NE = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset, en, halt, clear, snap;
  logic [NE-1:0] evt;
  logic [SW-1:0] rd_sel;
  logic [31:0]   rd_a;
  logic [3:0]    rd_w, rd_s;
  logic [NE:0]   ovf_a, ovf_w, ovf_s;
  logic          frz_a, frz_w, frz_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.CNT_W(32), .NUM_EVT(NE), .SAT_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .halt(halt), .clear(clear), .evt(evt),
    .snap(snap), .rd_sel(rd_sel), .rd_data(rd_a), .ovf(ovf_a), .frozen(frz_a));

  perf_counter_bank #(.CNT_W(4), .NUM_EVT(NE), .SAT_MODE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .halt(halt), .clear(clear), .evt(evt),
    .snap(snap), .rd_sel(rd_sel), .rd_data(rd_w), .ovf(ovf_w), .frozen(frz_w));

  perf_counter_bank #(.CNT_W(4), .NUM_EVT(NE), .SAT_MODE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .halt(halt), .clear(clear), .evt(evt),
    .snap(snap), .rd_sel(rd_sel), .rd_data(rd_s), .ovf(ovf_s), .frozen(frz_s));

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; halt = 1'b0; clear = 1'b0; snap = 1'b0;
    evt = '0; rd_sel = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1; tick(); snap = 1'b0;
  endtask

  task automatic do_read(input int sel);
    rd_sel = SW'(sel); tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_a !== 32'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd_a); end
    checks++; if (ovf_a !== 9'd0) begin failures++; $display("FAIL reset_ovf got=%h exp=0", ovf_a); end
    checks++; if (frz_a !== 1'b0) begin failures++; $display("FAIL reset_frozen got=%b exp=0", frz_a); end
  endtask

  task automatic test_basic_count();
    do_reset();
    en = 1'b1; evt = 8'b0000_0101;
    tick(10);
    en = 1'b0; evt = '0;
    do_snap();
    do_read(0); checks++; if (rd_a !== 32'd10) begin failures++; $display("FAIL basic_sel0 got=%0d exp=10", rd_a); end
    do_read(1); checks++; if (rd_a !== 32'd0)  begin failures++; $display("FAIL basic_sel1 got=%0d exp=0", rd_a); end
    do_read(2); checks++; if (rd_a !== 32'd10) begin failures++; $display("FAIL basic_sel2 got=%0d exp=10", rd_a); end
    do_read(8); checks++; if (rd_a !== 32'd10) begin failures++; $display("FAIL basic_cycle got=%0d exp=10", rd_a); end
    checks++; if (ovf_a !== 9'd0) begin failures++; $display("FAIL basic_ovf got=%h exp=0", ovf_a); end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    en = 1'b1; evt = 8'b0000_1000;
    tick(17);
    en = 1'b0; evt = '0;
    do_snap();
    do_read(3);
    checks++; if (rd_w !== 4'd1)  begin failures++; $display("FAIL wrap_cnt3 got=%0d exp=1", rd_w); end
    checks++; if (rd_s !== 4'd15) begin failures++; $display("FAIL sat_cnt3 got=%0d exp=15", rd_s); end
    checks++; if (rd_a !== 32'd17) begin failures++; $display("FAIL wide_cnt3 got=%0d exp=17", rd_a); end
    do_read(8);
    checks++; if (rd_w !== 4'd1)  begin failures++; $display("FAIL wrap_cycle got=%0d exp=1", rd_w); end
    checks++; if (rd_s !== 4'd15) begin failures++; $display("FAIL sat_cycle got=%0d exp=15", rd_s); end
    checks++; if (ovf_w !== 9'h108) begin failures++; $display("FAIL wrap_ovf got=%h exp=108", ovf_w); end
    checks++; if (ovf_s !== 9'h108) begin failures++; $display("FAIL sat_ovf got=%h exp=108", ovf_s); end
    checks++; if (ovf_a !== 9'h000) begin failures++; $display("FAIL wide_ovf got=%h exp=0", ovf_a); end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (ovf_w !== 9'h000) begin failures++; $display("FAIL wrap_ovf_clr got=%h exp=0", ovf_w); end
  endtask

  task automatic test_halt();
    do_reset();
    en = 1'b1; evt = '0;
    tick(5);
    halt = 1'b1; evt = 8'h40;
    tick();
    halt = 1'b0; evt = 8'hFF;
    tick(5);
    evt = '0;
    checks++; if (frz_a !== 1'b1) begin failures++; $display("FAIL halt_frozen got=%b exp=1", frz_a); end
    do_snap();
    do_read(6); checks++; if (rd_a !== 32'd1) begin failures++; $display("FAIL halt_cnt6 got=%0d exp=1", rd_a); end
    do_read(8); checks++; if (rd_a !== 32'd6) begin failures++; $display("FAIL halt_cycle got=%0d exp=6", rd_a); end
    do_read(0); checks++; if (rd_a !== 32'd0) begin failures++; $display("FAIL halt_cnt0 got=%0d exp=0", rd_a); end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (frz_a !== 1'b0) begin failures++; $display("FAIL halt_unfreeze got=%b exp=0", frz_a); end
    tick(3);
    do_snap();
    en = 1'b0;
    do_read(8); checks++; if (rd_a !== 32'd3) begin failures++; $display("FAIL halt_resume got=%0d exp=3", rd_a); end
  endtask

  task automatic test_snap_clear();
    do_reset();
    en = 1'b1; evt = 8'h01;
    tick(7);
    snap = 1'b1; clear = 1'b1;
    tick();
    snap = 1'b0; clear = 1'b0; en = 1'b0; evt = '0;
    do_read(0); checks++; if (rd_a !== 32'd7) begin failures++; $display("FAIL snapclr_shadow got=%0d exp=7", rd_a); end
    do_snap();
    do_read(0); checks++; if (rd_a !== 32'd0) begin failures++; $display("FAIL snapclr_live got=%0d exp=0", rd_a); end
    en = 1'b1; evt = 8'h01;
    tick(3);
    en = 1'b0; evt = '0;
    do_snap();
    do_read(0); checks++; if (rd_a !== 32'd3) begin failures++; $display("FAIL snapclr_next got=%0d exp=3", rd_a); end
  endtask

  task automatic test_enable_clear_halt();
    do_reset();
    en = 1'b1; evt = 8'hFF;
    tick(2);
    en = 1'b0;
    tick(4);
    do_snap();
    do_read(0); checks++; if (rd_a !== 32'd2) begin failures++; $display("FAIL en_cnt0 got=%0d exp=2", rd_a); end
    do_read(7); checks++; if (rd_a !== 32'd2) begin failures++; $display("FAIL en_cnt7 got=%0d exp=2", rd_a); end
    do_read(8); checks++; if (rd_a !== 32'd2) begin failures++; $display("FAIL en_cycle got=%0d exp=2", rd_a); end
    en = 1'b1; halt = 1'b1; clear = 1'b1;
    tick();
    halt = 1'b0; clear = 1'b0; en = 1'b0; evt = '0;
    checks++; if (frz_a !== 1'b0) begin failures++; $display("FAIL clrhalt_frozen got=%b exp=0", frz_a); end
    do_snap();
    do_read(0); checks++; if (rd_a !== 32'd0) begin failures++; $display("FAIL clrhalt_cnt0 got=%0d exp=0", rd_a); end
    do_read(8); checks++; if (rd_a !== 32'd0) begin failures++; $display("FAIL clrhalt_cycle got=%0d exp=0", rd_a); end
  endtask

  task automatic test_bad_sel_and_reset();
    do_reset();
    en = 1'b1; evt = 8'hFF;
    tick(3);
    en = 1'b0; evt = '0;
    do_snap();
    do_read(0);  checks++; if (rd_a !== 32'd3) begin failures++; $display("FAIL sel_valid got=%0d exp=3", rd_a); end
    do_read(9);  checks++; if (rd_a !== 32'd0) begin failures++; $display("FAIL sel_9 got=%0d exp=0", rd_a); end
    do_read(15); checks++; if (rd_a !== 32'd0) begin failures++; $display("FAIL sel_15 got=%0d exp=0", rd_a); end
    en = 1'b1; evt = 8'hFF; halt = 1'b1;
    tick();
    halt = 1'b0; rd_sel = '0;
    tick();
    checks++; if (frz_a !== 1'b1) begin failures++; $display("FAIL midrst_pre_frozen got=%b exp=1", frz_a); end
    checks++; if (rd_a !== 32'd3) begin failures++; $display("FAIL midrst_pre_rd got=%0d exp=3", rd_a); end
    reset = 1'b1;
    tick();
    reset = 1'b0; en = 1'b0; evt = '0;
    checks++; if (rd_a !== 32'd0)  begin failures++; $display("FAIL midrst_rd got=%0d exp=0", rd_a); end
    checks++; if (frz_a !== 1'b0)  begin failures++; $display("FAIL midrst_frozen got=%b exp=0", frz_a); end
    checks++; if (ovf_w !== 9'h0)  begin failures++; $display("FAIL midrst_ovf got=%h exp=0", ovf_w); end
    do_snap();
    do_read(8); checks++; if (rd_a !== 32'd0) begin failures++; $display("FAIL midrst_live got=%0d exp=0", rd_a); end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_wrap_sat();
    test_halt();
    test_snap_clear();
    test_enable_clear_halt();
    test_bad_sel_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
